spi_rom_fetch: RTL and testbench
================================

// Module: spi_rom_fetch
// PURPOSE
//   Instruction/operand fetch engine between the control unit and the external SPI
//   flash/PSRAM. Takes a 23-bit PC-style address, runs one SPI mode-0 READ transaction
//   (cmd, 24-bit address, N data bytes) and returns the fetched word with a done pulse.
//   Its data output feeds the CU's instruction-register input; its address comes from the CU's pc.
// PARAMETERS
//   CLK_DIV     1      clk cycles per SCK half-period (>=1)
//   DATA_BYTES  1      bytes read per transaction (1..4); DW = 8*DATA_BYTES
//   READ_CMD    8'h03  SPI read opcode sent first
// PORTS
//   clk       in   1     system clock, all logic on posedge
//   rst_n     in   1     asynchronous, active-low reset
//   req       in   1     start request, sampled only in IDLE
//   addr      in   23    byte address, latched when req accepted
//   data      out  DW    fetched word, first byte received in MSBs
//   done      out  1     one-cycle pulse: data valid from this cycle onward
//   busy      out  1     high from accept cycle+1 through DONE cycle
//   spi_cs_n  out  1     chip select, active low
//   spi_sck   out  1     serial clock, idles low (mode 0)
//   spi_mosi  out  1     serial data out, MSB first
//   spi_miso  in   1     serial data in
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, data=0,
//     done=0, busy=0. Reset mid-transaction aborts immediately; CS deasserts the same cycle.
//   Frame: NB = 32 + 8*DATA_BYTES bits, shifted as {READ_CMD, 1'b0, addr, DW don't-care}.
//   States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: cs_n=1, sck=0, busy=0. If req=1: latch addr, load shift reg, go SHIFT.
//     req while not IDLE is ignored (no queueing).
//   SHIFT: cs_n=0, busy=1. First SHIFT cycle: mosi = frame bit NB-1, sck=0.
//     Half-period counter counts CLK_DIV cycles, then toggles sck.
//     sck 0->1: no data change. sck 1->0 (end of high half): sample spi_miso into data
//       shift reg if current bit index is in the data phase (last DW bits); then drive
//       next frame bit on mosi.
//     Bit counter (6 bits) counts NB falling edges; after the NB-th falling edge go DONE.
//     mosi during data phase = 0.
//   DONE: exactly 1 cycle; cs_n=1, sck=0, mosi=0, done=1, busy=1; data updated. Then IDLE.
//   Latency: req sampled in IDLE at cycle T -> done=1 at cycle T+1+2*CLK_DIV*NB
//     (CLK_DIV=1, DATA_BYTES=1: T+81).
//   data holds its value until the next DONE; not cleared by new req.
//   CS high time between back-to-back transactions >= 2 cycles (DONE + IDLE accept cycle).
//   Address bit 23 sent as 0; addr is 23 bits, no wrap handling needed here.
// TESTING
//   1 Reset: hold rst_n=0 mid-frame -> cs_n=1, sck=0, mosi=0, done=0, busy=0 same cycle;
//     after release, state is IDLE.
//   2 Single read, defaults: req with addr=23'h000123; flash model returns 8'hA5 ->
//     MOSI bytes 03 00 01 23, 40 SCK rising edges, done at T+81, data=8'hA5.
//   3 Busy ignore: pulse req with addr=23'h7FFFFF at T+10 during test 2 ->
//     second request ignored; MOSI still 03 00 01 23; exactly one done pulse.
//   4 Back-to-back: hold req=1 continuously, addr=0x10 then 0x11 -> two frames;
//     cs_n high exactly 2 cycles between them; data 8'h11 then 8'h22 from model.
//   5 CLK_DIV=3, DATA_BYTES=2: addr=23'h400000, model returns BEEF ->
//     sck half-period 3 cycles, MOSI 03 40 00 00, done at T+289, data=16'hBEEF.
//   6 Reset mid-data-phase then new req addr=0x5 -> clean full frame 03 00 00 05;
//     no done for the aborted frame.

Source files
------------

// File: rtl/spi_rom_fetch.sv
// spi_rom_fetch: single-transaction SPI mode-0 READ engine.
// A request in IDLE sends {READ_CMD, 0, addr[22:0]} followed by DATA_BYTES
// of don't-care clocks. The bytes clocked in on MISO are returned on data,
// first byte in the MSBs, together with a one-cycle done pulse.
module spi_rom_fetch #(
    parameter int          CLK_DIV    = 1,
    parameter int          DATA_BYTES = 1,
    parameter logic [7:0]  READ_CMD   = 8'h03
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    input  logic [22:0]               addr,
    output logic [8*DATA_BYTES-1:0]   data,
    output logic                      done,
    output logic                      busy,
    output logic                      spi_cs_n,
    output logic                      spi_sck,
    output logic                      spi_mosi,
    input  logic                      spi_miso
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int NB = 32 + DW;
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [NB-1:0]   shift_reg;
    logic [DW-2:0]   rx_reg;
    logic [CW-1:0]   half_cnt;
    logic [5:0]      bit_cnt;

    // Whole fetch engine: accepts a request, clocks the frame out and the reply in,
    // then presents the word for one DONE cycle before returning to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            spi_cs_n  <= 1'b1;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            data      <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            shift_reg <= '0;
            rx_reg    <= '0;
            half_cnt  <= '0;
            bit_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    spi_cs_n <= 1'b1;
                    spi_sck  <= 1'b0;
                    spi_mosi <= 1'b0;
                    busy     <= 1'b0;
                    if (req) begin
                        shift_reg <= {READ_CMD, 1'b0, addr, {DW{1'b0}}};
                        spi_mosi  <= READ_CMD[7];
                        spi_cs_n  <= 1'b0;
                        busy      <= 1'b1;
                        half_cnt  <= '0;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (half_cnt == CW'(CLK_DIV - 1)) begin
                        half_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt >= 6'd32) begin
                                rx_reg <= {rx_reg[DW-3:0], spi_miso};
                            end
                            if (bit_cnt == 6'(NB - 1)) begin
                                data     <= {rx_reg, spi_miso};
                                done     <= 1'b1;
                                spi_cs_n <= 1'b1;
                                spi_mosi <= 1'b0;
                                state    <= DONE;
                            end else begin
                                bit_cnt   <= bit_cnt + 6'd1;
                                shift_reg <= shift_reg << 1;
                                spi_mosi  <= shift_reg[NB-2];
                            end
                        end
                    end else begin
                        half_cnt <= half_cnt + CW'(1);
                    end
                end

                DONE: begin
                    spi_cs_n <= 1'b1;
                    spi_sck  <= 1'b0;
                    spi_mosi <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    spi_cs_n <= 1'b1;
                    spi_sck  <= 1'b0;
                    spi_mosi <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rom_fetch.sv
// tb_spi_rom_fetch: two engines (default build and CLK_DIV=3/DATA_BYTES=2)
// talking to a behavioural SPI flash. Expected words come from a byte-addressed
// memory model; a monitor pops the scoreboard on every done pulse.
module tb_spi_rom_fetch;

    localparam logic [7:0] CMD = 8'h03;

    typedef struct {
        logic [31:0] data;
        logic [31:0] hdr;
        int          doneCyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [22:0] addr0 = '0;
    logic [22:0] addr1 = '0;
    logic [7:0]  data0;
    logic [15:0] data1;
    logic [1:0]  done, busy, cs_n, sck, mosi;
    logic [1:0]  miso = 2'b00;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    exp_t sbq0[$];
    exp_t sbq1[$];
    logic [31:0] lastData [2] = '{32'h0, 32'h0};

    logic [7:0]  mem [int];
    int          rc [2] = '{0, 0};
    int          lastRc [2] = '{0, 0};
    int          merr [2] = '{0, 0};
    int          lastMerr [2] = '{0, 0};
    logic [31:0] hdr [2] = '{32'h0, 32'h0};

    spi_rom_fetch u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .addr(addr0), .data(data0),
        .done(done[0]), .busy(busy[0]), .spi_cs_n(cs_n[0]), .spi_sck(sck[0]),
        .spi_mosi(mosi[0]), .spi_miso(miso[0])
    );

    spi_rom_fetch #(.CLK_DIV(3), .DATA_BYTES(2), .READ_CMD(8'h03)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .addr(addr1), .data(data1),
        .done(done[1]), .busy(busy[1]), .spi_cs_n(cs_n[1]), .spi_sck(sck[1]),
        .spi_mosi(mosi[1]), .spi_miso(miso[1])
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used for latency expectations
    always @(posedge clk) cyc++;

    function automatic int nbOf(input int g);
        return (g == 0) ? 40 : 48;
    endfunction

    function automatic int cdOf(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int bytesOf(input int g);
        return (g == 0) ? 1 : 2;
    endfunction

    function automatic logic [7:0] memByte(input logic [23:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] expData(input int g, input logic [22:0] a);
        logic [31:0] d = 32'h0;
        for (int k = 0; k < bytesOf(g); k++) begin
            d = (d << 8) | 32'(memByte({1'b0, a} + 24'(k)));
        end
        return d;
    endfunction

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, want);
        end
    endfunction

    function automatic int qsize(input int g);
        return (g == 0) ? sbq0.size() : sbq1.size();
    endfunction

    function automatic void pushExp(input int g, input logic [22:0] a, input int doneCyc);
        exp_t e;
        e.data = expData(g, a);
        e.hdr = {CMD, 1'b0, a};
        e.doneCyc = doneCyc;
        if (g == 0) sbq0.push_back(e);
        else sbq1.push_back(e);
    endfunction

    // Behavioural SPI flash per engine: captures the header on SCK rise, streams memory bytes on SCK fall
    for (genvar g = 0; g < 2; g++) begin : g_flash
        always @(posedge sck[g] or posedge cs_n[g]) begin
            if (cs_n[g] === 1'b1) begin
                lastRc[g] = rc[g];
                lastMerr[g] = merr[g];
                rc[g] = 0;
                merr[g] = 0;
            end else begin
                if (rc[g] < 32) hdr[g] = {hdr[g][30:0], mosi[g]};
                else if (mosi[g] !== 1'b0) merr[g]++;
                rc[g]++;
            end
        end

        always @(negedge sck[g]) begin
            int k;
            logic [7:0] bv;
            if (cs_n[g] === 1'b0 && rc[g] >= 32) begin
                k = rc[g] - 32;
                bv = memByte(hdr[g][23:0] + 24'(k / 8));
                miso[g] = bv[7 - (k % 8)];
            end
        end
    end

    function automatic void checkTxn(input int g, input exp_t e, input logic [31:0] got);
        check($sformatf("data_dut%0d", g), got, e.data);
        check($sformatf("mosi_header_dut%0d", g), hdr[g], e.hdr);
        check($sformatf("sck_rises_dut%0d", g), 32'(lastRc[g]), 32'(nbOf(g)));
        check($sformatf("done_cycle_dut%0d", g), 32'(cyc), 32'(e.doneCyc));
        check($sformatf("mosi_data_phase_dut%0d", g), 32'(lastMerr[g]), 32'(0));
    endfunction

    // Scoreboard monitor: every done pulse pops one expected transaction
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (done[0] === 1'b1) begin
                if (sbq0.size() == 0) check("spurious_done_dut0", 32'(done[0]), 32'(0));
                else begin
                    e = sbq0.pop_front();
                    checkTxn(0, e, 32'(data0));
                end
            end
            if (done[1] === 1'b1) begin
                if (sbq1.size() == 0) check("spurious_done_dut1", 32'(done[1]), 32'(0));
                else begin
                    e = sbq1.pop_front();
                    checkTxn(1, e, 32'(data1));
                end
            end
        end
    end

    // Issues a request from a negedge; checks the accept response one cycle later
    task automatic applyStimulus(input int g, input logic [22:0] a, input bit expectDone, input bit holdReq);
        if (g == 0) addr0 = a;
        else addr1 = a;
        req[g] = 1'b1;
        if (expectDone) pushExp(g, a, cyc + 1 + 2 * cdOf(g) * nbOf(g));
        @(negedge clk);
        if (!holdReq) req[g] = 1'b0;
        check($sformatf("busy_after_accept_dut%0d", g), 32'(busy[g]), 32'(1));
        check($sformatf("cs_after_accept_dut%0d", g), 32'(cs_n[g]), 32'(0));
        check($sformatf("data_held_dut%0d", g), (g == 0) ? 32'(data0) : 32'(data1), lastData[g]);
        if (expectDone) lastData[g] = expData(g, a);
    endtask

    task automatic checkOutput(input int g, input string tag);
        check($sformatf("%s_cs_n_dut%0d", tag, g), 32'(cs_n[g]), 32'(1));
        check($sformatf("%s_sck_dut%0d", tag, g), 32'(sck[g]), 32'(0));
        check($sformatf("%s_mosi_dut%0d", tag, g), 32'(mosi[g]), 32'(0));
        check($sformatf("%s_done_dut%0d", tag, g), 32'(done[g]), 32'(0));
        check($sformatf("%s_busy_dut%0d", tag, g), 32'(busy[g]), 32'(0));
        check($sformatf("%s_data_dut%0d", tag, g), (g == 0) ? 32'(data0) : 32'(data1), 32'(0));
    endtask

    task automatic waitIdle(input int g, input int budget);
        int n = 0;
        while ((qsize(g) != 0 || busy[g] !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout_dut%0d: still busy after %0d cycles, required idle", g, budget);
            if (g == 0) sbq0.delete();
            else sbq1.delete();
        end
    endtask

    // Directed scenarios followed by randomized fetches on both engines
    initial begin
        int n;
        int g;
        logic [22:0] a;

        mem[32'h000123] = 8'hA5;
        mem[32'h000010] = 8'h11;
        mem[32'h000011] = 8'h22;
        mem[32'h400000] = 8'hBE;
        mem[32'h400001] = 8'hEF;

        repeat (2) @(negedge clk);
        checkOutput(0, "reset");
        checkOutput(1, "reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single read plus an ignored request while busy
        applyStimulus(0, 23'h000123, 1'b1, 1'b0);
        repeat (9) @(negedge clk);
        addr0 = 23'h7FFFFF;
        req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        waitIdle(0, 600);
        repeat (100) @(negedge clk);

        // Back-to-back with req held high
        applyStimulus(0, 23'h000010, 1'b1, 1'b1);
        n = 0;
        while (done[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL timeout_b2b: no done within %0d cycles, required done", n);
        end
        addr0 = 23'h000011;
        pushExp(0, 23'h000011, cyc + 2 + 2 * cdOf(0) * nbOf(0));
        n = 0;
        while (cs_n[0] === 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("cs_high_gap", 32'(n), 32'(2));
        req[0] = 1'b0;
        lastData[0] = 32'h22;
        waitIdle(0, 600);

        // Divided clock, two data bytes
        applyStimulus(1, 23'h400000, 1'b1, 1'b0);
        n = 0;
        while (sck[1] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (sck[1] === 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("sck_high_half_dut1", 32'(n), 32'(3));
        waitIdle(1, 600);

        // Abort during the data phase, then a clean frame
        applyStimulus(0, 23'h000055, 1'b0, 1'b0);
        repeat (70) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checkOutput(0, "abort");
        @(negedge clk);
        rst_n = 1'b1;
        lastData[0] = 32'h0;
        lastData[1] = 32'h0;
        @(negedge clk);
        check("idle_after_abort_busy", 32'(busy[0]), 32'(0));
        check("idle_after_abort_cs", 32'(cs_n[0]), 32'(1));
        applyStimulus(0, 23'h000005, 1'b1, 1'b0);
        waitIdle(0, 600);

        // Randomized fetches
        for (int i = 0; i < 12; i++) begin
            g = int'($urandom_range(0, 1));
            a = 23'($urandom);
            if ($urandom_range(0, 1) == 1) mem[int'({1'b0, a})] = 8'($urandom);
            applyStimulus(g, a, 1'b1, 1'b0);
            waitIdle(g, 600);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
